cop_driver: RTL and testbench

- CPU-side initiator for the GCD/LCM coprocessor link.
- Accepts a request from the RISC-V core through a valid/ready handshake: opcode plus two 32-bit operands.
- Serialises the request onto the coprocessor's Start/WriteData interface, holds Start for the required number of cycles, and samples ReadData.
- Returns the result to the core through a valid/ready response channel; `busy` stalls the core pipeline while a transaction is in flight.

---
 rtl/cop_pkg.sv | 42 ++++
 rtl/cop_driver.sv | 247 ++++++++++++++++++++++++
 tb/tb_cop_driver.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cop_pkg.sv
// -----------------------------------------------------------------------------
// cop_pkg
// Shared definitions for the GCD/LCM coprocessor link. The driver on the CPU
// side and the coprocessor itself both import this package so that data width,
// Start latency and opcode encodings cannot drift apart.
//
// Contents:
//   COP_WIDTH    - operand / WriteData / ReadData width
//   COP_LATENCY  - Start-high cycles the coprocessor needs before its result
//   COP_CNT_W    - width of the Start-cycle counter (must hold COP_LATENCY+1)
//   cop_op_t     - opcode encoding carried in the third serialised word
//   cop_state_t  - driver FSM states
//   is_legal_op  - opcode legality check used at request acceptance
// -----------------------------------------------------------------------------
package cop_pkg;

    localparam int COP_WIDTH   = 32;
    localparam int COP_LATENCY = 6;
    localparam int COP_CNT_W   = 4;

    typedef enum logic [1:0] {
        OP_GCD = 2'b00,
        OP_LCM = 2'b01
    } cop_op_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_A  = 3'd1,
        SEND_B  = 3'd2,
        SEND_OP = 3'd3,
        WAIT    = 3'd4,
        CAPTURE = 3'd5,
        RESP    = 3'd6
    } cop_state_t;

    // Only the two defined opcodes reach the coprocessor; 10/11 are answered
    // locally with an error response.
    function automatic logic is_legal_op(input logic [1:0] op);
        return (op == OP_GCD) || (op == OP_LCM);
    endfunction

endpackage

// File: rtl/cop_driver.sv
// -----------------------------------------------------------------------------
// cop_driver
// CPU-side initiator for the GCD/LCM coprocessor. A request (opcode + two
// operands) is taken from the core over a valid/ready handshake, serialised as
// three WriteData words (A, B, opcode) under a continuous Start pulse of
// LATENCY+1 cycles, and the coprocessor's ReadData is captured in the cycle
// after Start falls. The result is offered back to the core over a valid/ready
// response channel. Illegal opcodes are answered immediately with resp_err=1
// and never touch the coprocessor.
//
// Parameters:
//   WIDTH    data width of operands, WriteData, ReadData and result
//   LATENCY  Start-high cycles the coprocessor needs (>= 3)
//   CNT_W    Start-cycle counter width (must hold LATENCY+1)
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   req_valid/req_ready     request handshake from the core
//   req_op, req_a, req_b    opcode and operands
//   resp_valid/resp_ready   response handshake to the core
//   resp_data, resp_err     result and illegal-opcode flag
//   flush                   synchronous abort from the core
//   busy                    transaction in flight (pipeline stall)
//   Start, WriteData        coprocessor command interface
//   ReadData                coprocessor result
//
// All coprocessor/response outputs are registered. They are computed from the
// next state so that they line up with the state they belong to; req_ready and
// busy are plain decodes of the registered state.
// -----------------------------------------------------------------------------
module cop_driver
    import cop_pkg::*;
#(
    parameter int WIDTH   = COP_WIDTH,
    parameter int LATENCY = COP_LATENCY,
    parameter int CNT_W   = COP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    input  logic             flush,
    output logic             busy,
    output logic             Start,
    output logic [WIDTH-1:0] WriteData,
    input  logic [WIDTH-1:0] ReadData
);

    // -------------------------------------------------------------------------
    // Elaboration-time parameter checks
    // -------------------------------------------------------------------------
    generate
        if (LATENCY < 3) begin : g_bad_latency
            $error("cop_driver: LATENCY must be at least 3 (three words are serialised under Start)");
        end
        if ((LATENCY + 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("cop_driver: CNT_W too narrow to hold LATENCY+1");
        end
    endgenerate

    // Counter value of the final Start-high cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY + 1);

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    cop_state_t       r_state;
    cop_state_t       w_state_next;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_b;

    logic             r_start;
    logic [WIDTH-1:0] r_wdata;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_data;
    logic             r_resp_err;

    logic             w_start_next;
    logic [WIDTH-1:0] w_wdata_next;
    logic             w_resp_valid_next;

    logic             w_accept;
    logic             w_legal;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    // rst_n is folded in so the core never sees a ready while reset is held,
    // even though the reset state is IDLE.
    assign req_ready = rst_n && (r_state == IDLE) && !flush;
    assign busy      = (r_state != IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_legal   = is_legal_op(req_op);

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            // Abort wins over everything, including a same-cycle resp_ready.
            // In IDLE this is a no-op because req_ready is already held low.
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        w_state_next = w_legal ? SEND_A : RESP;
                    end
                end
                SEND_A:  w_state_next = SEND_B;
                SEND_B:  w_state_next = SEND_OP;
                SEND_OP: w_state_next = WAIT;
                WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_next = CAPTURE;
                    end
                end
                CAPTURE: w_state_next = RESP;
                RESP: begin
                    if (resp_ready) begin
                        w_state_next = IDLE;
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: output logic (values to be registered alongside the next state)
    // -------------------------------------------------------------------------
    // r_cnt holds the 1-based index of the current Start-high cycle, so it is
    // 1 in SEND_A and reaches LATENCY+1 in the last WAIT cycle. Any state that
    // does not drive Start clears it.
    always_comb begin
        w_start_next      = 1'b0;
        w_wdata_next      = '0;
        w_cnt_next        = '0;
        w_resp_valid_next = (w_state_next == RESP);
        case (w_state_next)
            SEND_A: begin
                // SEND_A is only entered from IDLE on acceptance, so the
                // operand is taken straight from the request bus; the
                // WriteData register is its latch.
                w_start_next = 1'b1;
                w_wdata_next = req_a;
                w_cnt_next   = CNT_W'(1);
            end
            SEND_B: begin
                w_start_next = 1'b1;
                w_wdata_next = r_b;
                w_cnt_next   = r_cnt + 1'b1;
            end
            SEND_OP: begin
                w_start_next = 1'b1;
                w_wdata_next = WIDTH'(r_op);
                w_cnt_next   = r_cnt + 1'b1;
            end
            WAIT: begin
                w_start_next = 1'b1;
                w_cnt_next   = r_cnt + 1'b1;
            end
            default: begin
                w_start_next = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered outputs and counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_start      <= 1'b0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
        end else begin
            r_start      <= w_start_next;
            r_wdata      <= w_wdata_next;
            r_cnt        <= w_cnt_next;
            r_resp_valid <= w_resp_valid_next;
        end
    end

    // -------------------------------------------------------------------------
    // Request latches
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= '0;
            r_b  <= '0;
        end else if (w_accept) begin
            r_op <= req_op;
            r_b  <= req_b;
        end
    end

    // -------------------------------------------------------------------------
    // Response registers
    // -------------------------------------------------------------------------
    // Written only on the two edges that enter RESP, so the pair stays stable
    // for however long the core backpressures. ReadData is sampled only on
    // the CAPTURE edge; a flush in CAPTURE leaves the old response untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b0;
        end else if ((r_state == IDLE) && w_accept && !w_legal) begin
            r_resp_data <= '0;
            r_resp_err  <= 1'b1;
        end else if ((r_state == CAPTURE) && (w_state_next == RESP)) begin
            r_resp_data <= ReadData;
            r_resp_err  <= 1'b0;
        end
    end

    assign Start      = r_start;
    assign WriteData  = r_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_cop_driver.sv
// -----------------------------------------------------------------------------
// tb_cop_driver
// Directed bench for cop_driver with a behavioural GCD/LCM coprocessor model.
// The model records the three WriteData words seen under Start, counts the
// Start-high run length, and drives the result on ReadData only in the first
// Start-low cycle after a run of exactly LATENCY+1 cycles.
// -----------------------------------------------------------------------------
module tb_cop_driver;
    import cop_pkg::*;

    localparam int W = COP_WIDTH;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_err;
    logic         flush;
    logic         busy;
    logic         Start;
    logic [W-1:0] WriteData;
    logic [W-1:0] ReadData;

    int n_checks = 0;
    int n_errors = 0;

    cop_driver #(
        .WIDTH   (W),
        .LATENCY (COP_LATENCY),
        .CNT_W   (COP_CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .flush      (flush),
        .busy       (busy),
        .Start      (Start),
        .WriteData  (WriteData),
        .ReadData   (ReadData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural coprocessor
    // ------------------------------------------------------------------
    function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] lcm(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] g;
        g = gcd(a, b);
        if (g == 0) return '0;
        return (a / g) * b;
    endfunction

    int           run;
    int           last_run;
    logic [W-1:0] w0, w1, w2;
    logic [W-1:0] model_result;
    logic [W-1:0] rd_idle;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run      <= 0;
            last_run <= 0;
            w0       <= '0;
            w1       <= '0;
            w2       <= '0;
        end else if (Start) begin
            case (run)
                0:       w0 <= WriteData;
                1:       w1 <= WriteData;
                2:       w2 <= WriteData;
                default: ;
            endcase
            run <= run + 1;
        end else if (run != 0) begin
            last_run <= run;
            run      <= 0;
        end
    end

    always_comb begin
        model_result = '0;
        if (w2[1:0] == 2'b00) model_result = gcd(w0, w1);
        else                  model_result = lcm(w0, w1);
    end

    assign ReadData = (!Start && run == COP_LATENCY + 1) ? model_result : rd_idle;

    // ------------------------------------------------------------------
    // Checking and stimulus helpers
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; the request is accepted on the next
    // rising edge if the driver is idle.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
    endtask

    // Returns the number of falling edges until resp_valid is seen (1 means
    // the cycle right after acceptance). An expired bound counts as a failure.
    task automatic wait_resp(input string tag, input int limit, output int cycles);
        cycles = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (resp_valid) begin
                cycles = i;
                break;
            end
        end
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd1);
        if (resp_valid)
            $display("txn %s: resp_data=0x%08h resp_err=%0d latency=%0d", tag, resp_data, resp_err, cycles);
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int cyc;
    int sc;
    int nv;

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 2'b00;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b1;
        flush      = 1'b0;
        rd_idle    = 32'h0000_0010;

        // Reset values while rst_n is held low
        repeat (2) @(negedge clk);
        check("rst_start",      {31'd0, Start},      32'd0);
        check("rst_wdata",      WriteData,           32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_data",  resp_data,           32'd0);
        check("rst_resp_err",   {31'd0, resp_err},   32'd0);
        check("rst_busy",       {31'd0, busy},       32'd0);
        check("rst_req_ready",  {31'd0, req_ready},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // GCD(48,18) with cycle-exact timing
        issue(OP_GCD, 32'd48, 32'd18);
        sc = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            sc += int'(Start);
            if (c == 1) check("gcd_wd_a",  WriteData, 32'd48);
            if (c == 2) check("gcd_wd_b",  WriteData, 32'd18);
            if (c == 3) check("gcd_wd_op", WriteData, 32'd0);
            if (c == 7) check("gcd_start_c7", {31'd0, Start}, 32'd1);
            if (c == 8) begin
                check("gcd_start_c8", {31'd0, Start},      32'd0);
                check("gcd_rv_c8",    {31'd0, resp_valid}, 32'd0);
            end
        end
        check("gcd_start_cycles", sc, 32'd7);
        check("gcd_rv_c9",    {31'd0, resp_valid}, 32'd1);
        check("gcd_data",     resp_data,           32'd6);
        check("gcd_err",      {31'd0, resp_err},   32'd0);
        $display("txn gcd(48,18): resp_data=0x%08h resp_err=%0d", resp_data, resp_err);

        // LCM(4,6) issued while the first response is still on the bus
        issue(OP_LCM, 32'd4, 32'd6);
        #1;
        check("lcm_no_ready_in_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("lcm_idle_busy",  {31'd0, busy},      32'd0);
        check("lcm_idle_ready", {31'd0, req_ready}, 32'd1);
        wait_resp("lcm", 20, cyc);
        check("lcm_latency", cyc, 32'd9);
        check("lcm_data",    resp_data, 32'd12);
        check("lcm_err",     {31'd0, resp_err}, 32'd0);
        check("lcm_opword",  w2, 32'd1);
        check("lcm_run",     last_run, 32'd7);
        @(negedge clk);
        check("lcm_done_busy", {31'd0, busy}, 32'd0);

        // Illegal opcode
        issue(2'b11, 32'd5, 32'd7);
        wait_resp("illegal", 5, cyc);
        check("ill_latency", cyc, 32'd1);
        check("ill_err",     {31'd0, resp_err}, 32'd1);
        check("ill_data",    resp_data, 32'd0);
        check("ill_start",   {31'd0, Start}, 32'd0);
        @(negedge clk);
        check("ill_done_busy",  {31'd0, busy},  32'd0);
        check("ill_done_start", {31'd0, Start}, 32'd0);

        // Backpressure: ReadData sits at 0x10 outside CAPTURE
        resp_ready = 1'b0;
        issue(OP_GCD, 32'd100, 32'd75);
        wait_resp("bp", 20, cyc);
        check("bp_data", resp_data, 32'd25);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_hold_data",  resp_data,           32'd25);
            check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
            check("bp_hold_busy",  {31'd0, busy},       32'd1);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("bp_done_busy",  {31'd0, busy},       32'd0);
        check("bp_done_valid", {31'd0, resp_valid}, 32'd0);

        // flush in WAIT (cycle 5)
        issue(OP_GCD, 32'd48, 32'd18);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
        end
        check("fl_start_c5", {31'd0, Start}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fl_start_c6", {31'd0, Start},      32'd0);
        check("fl_rv_c6",    {31'd0, resp_valid}, 32'd0);
        check("fl_busy_c6",  {31'd0, busy},       32'd0);
        check("fl_ready_c6", {31'd0, req_ready},  32'd1);
        check("fl_wd_c6",    WriteData,           32'd0);
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            nv += int'(resp_valid);
        end
        check("fl_no_resp", nv, 32'd0);

        // flush in IDLE blocks acceptance
        flush = 1'b1;
        issue(OP_GCD, 32'd2, 32'd2);
        #1;
        check("fl_idle_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 1'b0;
        check("fl_idle_busy", {31'd0, busy}, 32'd0);

        issue(OP_GCD, 32'd9, 32'd3);
        wait_resp("gcd9_3", 20, cyc);
        check("gcd9_3_data", resp_data, 32'd3);
        @(negedge clk);

        // Asynchronous reset in SEND_B
        issue(OP_GCD, 32'd48, 32'd18);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("ar_start_sendb", {31'd0, Start}, 32'd1);
        check("ar_wd_sendb",    WriteData,      32'd18);
        rst_n = 1'b0;
        #1;
        check("ar_start",      {31'd0, Start},      32'd0);
        check("ar_wdata",      WriteData,           32'd0);
        check("ar_busy",       {31'd0, busy},       32'd0);
        check("ar_req_ready",  {31'd0, req_ready},  32'd0);
        check("ar_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ar_rel_ready", {31'd0, req_ready},  32'd1);
        check("ar_rel_data",  resp_data,           32'd0);
        check("ar_rel_err",   {31'd0, resp_err},   32'd0);
        check("ar_rel_start", {31'd0, Start},      32'd0);
        check("ar_rel_valid", {31'd0, resp_valid}, 32'd0);

        issue(OP_LCM, 32'd21, 32'd6);
        wait_resp("lcm21_6", 20, cyc);
        check("lcm21_6_data", resp_data, 32'd42);
        check("lcm21_6_run",  last_run,  32'd7);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
